mem_port_arbiter: RTL

Two-requester arbiter and access sequencer for the single-port 16-bit unified memory. It shares the memory between the multicycle CPU datapath (fetch/load/store) and the debug/test host port (memory read/write in test mode). Each access is a fixed three-cycle transaction: arbitrate, access, respond. The CPU control FSM is held off through `cpu_stall` while its request waits or is in flight.

---
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: serializes CPU and debug-host accesses to one single-port memory
// as grant/access/respond transactions. Define ARB_FAIRNESS_EN to bound debug bursts over a waiting CPU.
// Revision: 1.0
module mem_port_arbiter #(
  parameter int AW            = 16,
  parameter int DW            = 16,
  parameter int MAX_DBG_BURST = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_done,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_stall,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_gnt,
  output logic          dbg_done,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_owner_dbg;
  logic          r_mem_en;
  logic          r_mem_we;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_cpu_done;
  logic          r_dbg_done;

  logic          w_idle;
  logic          w_cpu_turn;
  logic          w_dbg_win;
  logic          w_cpu_gnt;
  logic          w_dbg_gnt;
  logic          w_sel_we;
  logic [AW-1:0] w_sel_addr;
  logic [DW-1:0] w_sel_wdata;

  // Grants are suppressed while reset is asserted so every output reads 0 during reset.
  assign w_idle = (r_state == S_IDLE) && reset;

`ifdef ARB_FAIRNESS_EN
  localparam int CW = (MAX_DBG_BURST < 1) ? 1 : $clog2(MAX_DBG_BURST + 1);
  localparam logic [CW-1:0] C_MAX = CW'(MAX_DBG_BURST);

  logic [CW-1:0] r_fair_cnt;

  assign w_cpu_turn = cpu_req && (r_fair_cnt == C_MAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fair_cnt <= '0;
    end else if (w_cpu_gnt) begin
      r_fair_cnt <= '0;
    end else if (w_dbg_gnt && cpu_req) begin
      if (r_fair_cnt != C_MAX) begin
        r_fair_cnt <= r_fair_cnt + 1'b1;
      end
    end else if ((r_state == S_IDLE) && !cpu_req) begin
      r_fair_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;

  assign w_cpu_turn   = 1'b0;
  assign w_unused_cfg = (MAX_DBG_BURST != 0);
`endif

  assign w_dbg_win   = dbg_req && !w_cpu_turn;
  assign w_dbg_gnt   = w_idle && w_dbg_win;
  assign w_cpu_gnt   = w_idle && cpu_req && !w_dbg_win;
  assign w_sel_we    = w_dbg_gnt ? dbg_we    : cpu_we;
  assign w_sel_addr  = w_dbg_gnt ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = w_dbg_gnt ? dbg_wdata : cpu_wdata;

  // The memory-side registers double as the latched request fields; they hold
  // non-zero values only during ACCESS.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_owner_dbg <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
    end else begin
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cpu_done  <= 1'b0;
      r_dbg_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cpu_gnt || w_dbg_gnt) begin
            r_owner_dbg <= w_dbg_gnt;
            r_mem_en    <= 1'b1;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_cpu_done <= !r_owner_dbg;
          r_dbg_done <= r_owner_dbg;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign cpu_gnt   = w_cpu_gnt;
  assign dbg_gnt   = w_dbg_gnt;
  assign cpu_done  = r_cpu_done;
  assign dbg_done  = r_dbg_done;
  assign cpu_rdata = r_cpu_done ? mem_rdata : '0;
  assign dbg_rdata = r_dbg_done ? mem_rdata : '0;
  assign cpu_stall = cpu_req && !r_cpu_done;
  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire
